// File: rtl/dcache_responder_pkg.sv
// Shared types for the data-side responder: FSM states, per-line storage record
// and the byte-lane helper used when merging stores into a 256-bit line.
package dcache_responder_pkg;

   localparam int LINE_BYTES  = 32;
   // Wide enough for the smallest legal index width (NUM_SETS=2); unused upper bits stay zero.
   localparam int TAG_FIELD_W = 27;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPARE,
      ST_WRITEBACK,
      ST_FILL
   } dcache_state_t;

   typedef struct packed {
      logic                   valid;
      logic                   dirty;
      logic [TAG_FIELD_W-1:0] tag;
      logic [255:0]           data;
   } dcache_line_t;

   function automatic logic [LINE_BYTES-1:0] line_byte_en(input logic [2:0] word,
                                                          input logic [3:0] mask);
      return {28'b0, mask} << {word, 2'b00};
   endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Direct-mapped line store: flop array with one combinational read port and one
// write port carrying per-byte data enables; valid/dirty clear on reset.
module dcache_line_array
   import dcache_responder_pkg::*;
#(
   parameter int NUM_SETS = 4,
   localparam int IDX_W   = $clog2(NUM_SETS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic                   rd_valid,
   output logic                   rd_dirty,
   output logic [TAG_FIELD_W-1:0] rd_tag,
   output logic [255:0]           rd_data,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [LINE_BYTES-1:0]  wr_byte_en,
   input  logic                   wr_valid,
   input  logic                   wr_dirty,
   input  logic [TAG_FIELD_W-1:0] wr_tag,
   input  logic [255:0]           wr_data
);

   dcache_line_t          lines_reg [NUM_SETS];
   logic [NUM_SETS-1:0]   set_we;

   for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set_we
      assign set_we[gi] = wr_en && !rst && (wr_idx == IDX_W'(gi));
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < NUM_SETS; s++) begin
         if (rst) begin
            lines_reg[s].valid <= 1'b0;
            lines_reg[s].dirty <= 1'b0;
         end else if (set_we[s]) begin
            lines_reg[s].valid <= wr_valid;
            lines_reg[s].dirty <= wr_dirty;
            lines_reg[s].tag   <= wr_tag;
         end
         // Data has no reset; only enabled byte lanes change.
         for (int b = 0; b < LINE_BYTES; b++) begin
            if (set_we[s] && wr_byte_en[b])
               lines_reg[s].data[b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   assign rd_valid = lines_reg[rd_idx].valid;
   assign rd_dirty = lines_reg[rd_idx].dirty;
   assign rd_tag   = lines_reg[rd_idx].tag;
   assign rd_data  = lines_reg[rd_idx].data;

endmodule

// File: rtl/dcache_responder.sv
// Single-outstanding data responder: latches one load/store, serves it from a
// direct-mapped write-back line store, filling/evicting over a blocking line port.
module dcache_responder
   import dcache_responder_pkg::*;
#(
   parameter int NUM_SETS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  d_addr,
   input  logic [3:0]   d_rmask,
   input  logic [3:0]   d_wmask,
   input  logic [31:0]  d_wdata,
   output logic [31:0]  data_in,
   output logic         data_valid,
   output logic [31:0]  dfp_addr,
   output logic         dfp_read,
   output logic         dfp_write,
   output logic [255:0] dfp_wdata,
   input  logic [255:0] dfp_rdata,
   input  logic         dfp_resp
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 32 - 5 - IDX_W;

   dcache_state_t state_reg, state_next;
   logic [31:0] addr_reg;
   logic [3:0]  wmask_reg;
   logic [31:0] wdata_reg;

   logic [IDX_W-1:0]       idx;
   logic [2:0]             word;
   logic [TAG_FIELD_W-1:0] req_tag;
   logic                   rd_valid, rd_dirty;
   logic [TAG_FIELD_W-1:0] rd_tag;
   logic [255:0]           rd_data;
   logic                   hit, victim_dirty, wb_phase, fill_phase, req_present;
   logic                   wr_en, wr_dirty;
   logic [LINE_BYTES-1:0]  wr_byte_en;
   logic [TAG_FIELD_W-1:0] wr_tag;
   logic [255:0]           wr_data;
   logic                   unused_addr_bits;

   assign idx     = addr_reg[5 +: IDX_W];
   assign word    = addr_reg[4:2];
   assign req_tag = TAG_FIELD_W'(addr_reg[31:5+IDX_W]);
   assign unused_addr_bits = ^addr_reg[1:0];

   assign req_present  = (d_rmask != 4'b0) || (d_wmask != 4'b0);
   assign hit          = rd_valid && (rd_tag == req_tag);
   assign victim_dirty = rd_valid && rd_dirty;
   // Memory requests go out already in the COMPARE cycle that detects the miss.
   assign wb_phase   = (state_reg == ST_WRITEBACK) ||
                       (state_reg == ST_COMPARE && !hit && victim_dirty);
   assign fill_phase = (state_reg == ST_FILL) ||
                       (state_reg == ST_COMPARE && !hit && !victim_dirty);

   dcache_line_array #(.NUM_SETS(NUM_SETS)) u_lines (
      .clk        (clk),
      .rst        (rst),
      .rd_idx     (idx),
      .rd_valid   (rd_valid),
      .rd_dirty   (rd_dirty),
      .rd_tag     (rd_tag),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_idx     (idx),
      .wr_byte_en (wr_byte_en),
      .wr_valid   (1'b1),
      .wr_dirty   (wr_dirty),
      .wr_tag     (wr_tag),
      .wr_data    (wr_data)
   );

   always_comb begin
      wr_en      = 1'b0;
      wr_byte_en = '0;
      wr_dirty   = 1'b0;
      wr_tag     = rd_tag;
      wr_data    = {8{wdata_reg}};
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (req_present) state_next = ST_COMPARE;
         ST_COMPARE: begin
            if (hit) begin
               state_next = ST_IDLE;
               if (wmask_reg != 4'b0) begin
                  wr_en      = 1'b1;
                  wr_byte_en = line_byte_en(word, wmask_reg);
                  wr_dirty   = 1'b1;
               end
            end else if (victim_dirty) begin
               state_next = ST_WRITEBACK;
            end else begin
               state_next = ST_FILL;
            end
         end
         ST_WRITEBACK: if (dfp_resp) begin
            wr_en      = 1'b1;
            state_next = ST_FILL;
         end
         ST_FILL: if (dfp_resp) begin
            wr_en      = 1'b1;
            wr_byte_en = '1;
            wr_tag     = req_tag;
            wr_data    = dfp_rdata;
            state_next = ST_COMPARE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         wmask_reg <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && req_present) begin
            addr_reg  <= d_addr;
            wmask_reg <= d_wmask;
            wdata_reg <= d_wdata;
         end
      end
   end

   assign data_valid = (state_reg == ST_COMPARE) && hit;
   assign data_in    = data_valid ? rd_data[{word, 5'b0} +: 32] : 32'b0;
   assign dfp_write  = wb_phase;
   assign dfp_read   = fill_phase;
   assign dfp_addr   = wb_phase   ? {rd_tag[TAG_W-1:0], idx, 5'b0} :
                       fill_phase ? {addr_reg[31:5], 5'b0} : 32'b0;
   assign dfp_wdata  = wb_phase ? rd_data : 256'b0;

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized bench: a behavioural cache/memory model predicts every response,
// line transfer and latency of dcache_responder, including reset during a fill.
module tb_dcache_responder;
   localparam int NUM_SETS = 4;
   localparam int IDX_W    = $clog2(NUM_SETS);

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  d_addr, d_wdata, data_in, dfp_addr;
   logic [3:0]   d_rmask, d_wmask;
   logic         data_valid, dfp_read, dfp_write, dfp_resp;
   logic [255:0] dfp_wdata, dfp_rdata;

   int total = 0;
   int bad   = 0;

   logic [255:0] mem [bit [31:0]];
   bit           m_valid [NUM_SETS];
   bit           m_dirty [NUM_SETS];
   logic [31:0]  m_line  [NUM_SETS];
   logic [255:0] m_data  [NUM_SETS];
   logic [31:0]  last_rd;

   dcache_responder #(.NUM_SETS(NUM_SETS)) dut (
      .clk(clk), .rst(rst), .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask),
      .d_wdata(d_wdata), .data_in(data_in), .data_valid(data_valid),
      .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
      .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mem_line(input logic [31:0] la);
      logic [255:0] v;
      if (!mem.exists(la)) begin
         for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
         mem[la] = v;
      end
      return mem[la];
   endfunction

   task automatic reset_dut();
      rst = 1'b1; d_rmask = '0; d_wmask = '0; dfp_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data_valid", 256'(data_valid), '0);
      chk("rst_data_in", 256'(data_in), '0);
      chk("rst_dfp_read", 256'(dfp_read), '0);
      chk("rst_dfp_write", 256'(dfp_write), '0);
      chk("rst_dfp_addr", 256'(dfp_addr), '0);
      chk("rst_dfp_wdata", dfp_wdata, '0);
      rst = 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin m_valid[s] = 0; m_dirty[s] = 0; end
   endtask

   // Called #1 after a rising edge with the responder idle; returns in the next idle cycle.
   task automatic do_req(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, input bit hold);
      logic [IDX_W-1:0] idx;
      logic [31:0]      la;
      logic [2:0]       w;
      logic [255:0]     line;
      bit               hit, evict, wb_seen, rd_seen, done;
      int               cyc, wb_resp, fill_resp, delay;
      idx   = addr[5 +: IDX_W];
      la    = {addr[31:5], 5'b0};
      w     = addr[4:2];
      hit   = m_valid[idx] && (m_line[idx] == la);
      evict = !hit && m_valid[idx] && m_dirty[idx];
      wb_seen = 0; rd_seen = 0; done = 0; wb_resp = -1; fill_resp = -1; delay = 0;
      d_addr = addr; d_rmask = rm; d_wmask = wm; d_wdata = wd;
      @(posedge clk); #1;
      if (!hold) begin
         d_rmask = '0; d_wmask = '0; d_addr = $urandom; d_wdata = $urandom;
      end
      cyc = 1;
      while (!done && cyc < 40) begin
         dfp_resp = 1'b0;
         chk("rw_exclusive", 256'(dfp_read & dfp_write), '0);
         if (data_valid) begin
            done = 1;
            line = hit ? m_data[idx] : mem_line(la);
            last_rd = data_in;
            chk("data_in", 256'(data_in), 256'(line[{w, 5'b0} +: 32]));
            chk("latency", 256'(cyc), 256'(hit ? 1 : fill_resp + 1));
            chk("traffic", 256'({wb_seen, rd_seen}), 256'({evict, !hit}));
            d_rmask = '0; d_wmask = '0;
         end else if (dfp_write) begin
            if (!wb_seen) begin
               wb_seen = 1;
               chk("wb_start", 256'(cyc), 256'(1));
               chk("wb_addr", 256'(dfp_addr), 256'(m_line[idx]));
               chk("wb_data", dfp_wdata, m_data[idx]);
               delay = $urandom_range(1, 4);
            end
            if (delay == 0) begin
               dfp_resp = 1'b1; wb_resp = cyc; mem[m_line[idx]] = m_data[idx];
            end else delay--;
         end else if (dfp_read) begin
            if (!rd_seen) begin
               rd_seen = 1;
               chk("rd_start", 256'(cyc), 256'(evict ? wb_resp + 1 : 1));
               chk("rd_addr", 256'(dfp_addr), 256'(la));
               delay = $urandom_range(1, 4);
            end
            if (delay == 0) begin
               dfp_rdata = mem_line(la); dfp_resp = 1'b1; fill_resp = cyc;
            end else delay--;
         end
         if (!done) begin @(posedge clk); #1; cyc++; end
      end
      chk("no_timeout", 256'(done), 256'(1));
      dfp_resp = 1'b0;
      @(posedge clk); #1;
      chk("idle_after", 256'({data_valid, dfp_read, dfp_write}), '0);
      if (!hit) begin
         m_valid[idx] = 1; m_dirty[idx] = 0; m_line[idx] = la; m_data[idx] = mem_line(la);
      end
      if (wm != 4'b0) begin
         for (int b = 0; b < 4; b++)
            if (wm[b]) m_data[idx][{w, 5'b0} + b*8 +: 8] = wd[b*8 +: 8];
         m_dirty[idx] = 1;
      end
      $display("req addr=%08h rm=%h wm=%h hit=%0d evict=%0d rd=%08h", addr, rm, wm, hit, evict, last_rd);
   endtask

   initial begin
      logic [255:0] l;
      logic [31:0]  a;
      logic [3:0]   rm, wm;
      d_addr = '0; d_wdata = '0; dfp_rdata = '0;
      reset_dut();

      // Cold load, store-byte hit, re-load of the merged word.
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      l[63:32] = 32'hDEADBEEF;
      mem[32'h1000_0000] = l;
      do_req(32'h1000_0004, 4'hF, 4'h0, 32'h0, 0);
      chk("cold_load", 256'(last_rd), 256'(32'hDEADBEEF));
      do_req(32'h1000_0004, 4'h0, 4'b0100, 32'h00AB_0000, 0);
      do_req(32'h1000_0004, 4'hF, 4'h0, 32'h0, 1);
      chk("store_merge", 256'(last_rd), 256'(32'hDEABBEEF));

      // Dirty eviction to the same index, then a mask-conflict store and re-eviction.
      do_req(32'h2000_0000, 4'hF, 4'h0, 32'h0, 0);
      do_req(32'h2000_0008, 4'hF, 4'h1, 32'h0000_0055, 0);
      do_req(32'h1000_0000, 4'hF, 4'h0, 32'h0, 0);

      // Back-to-back held hits.
      for (int i = 0; i < 6; i++) do_req(32'h1000_0000 + 32'(i*4), 4'hF, 4'h0, 32'h0, 1);

      // Reset while a fill is outstanding; the late response must be ignored.
      reset_dut();
      d_addr = 32'h3000_0020; d_rmask = 4'hF; d_wmask = '0;
      @(posedge clk); #1;
      d_rmask = '0;
      @(posedge clk); #1;
      chk("fill_pending", 256'(dfp_read), 256'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_drops_read", 256'(dfp_read), '0);
      dfp_rdata = '1; dfp_resp = 1'b1;
      @(posedge clk); #1;
      dfp_resp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("no_resp_after_rst", 256'({data_valid, dfp_read, dfp_write}), '0);
         @(posedge clk); #1;
      end
      for (int s = 0; s < NUM_SETS; s++) begin m_valid[s] = 0; m_dirty[s] = 0; end
      do_req(32'h3000_0020, 4'hF, 4'h0, 32'h0, 0);

      // Random mix over three conflicting tags per index.
      for (int n = 0; n < 150; n++) begin
         a  = {4'(1 + $urandom_range(0, 2)), 21'b0, 2'(IDX_W == 2 ? $urandom_range(0, 3) : 0),
               3'($urandom_range(0, 7)), 2'b00};
         rm = 4'($urandom);
         wm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         if (rm == 4'h0 && wm == 4'h0) rm = 4'hF;
         if ($urandom_range(0, 7) == 0) begin
            dfp_rdata = '1; dfp_resp = 1'b1;
            @(posedge clk); #1;
            dfp_resp = 1'b0;
         end
         do_req(a, rm, wm, $urandom, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcache_responder.md
# dcache_responder

Data-side memory responder for the out-of-order core: accepts the single outstanding load/store request presented by the memory queue (word-aligned address plus byte masks) and answers with a one-cycle `data_valid` pulse carrying the read word. Backs requests with a small direct-mapped, write-back line store and fills or evicts 256-bit lines over a blocking lower-level memory port. Sits between the memory queue and the cacheline adapter/DRAM model.

## Interface
- `NUM_SETS`, 4, number of direct-mapped lines (power of two, ≥2)
- `clk`  in  1  system clock
- `rst`  in  1  reset; **synchronous, active-high** (one clock `clk`, sampled on rising edge)
- `d_addr`  in  32  request address, bits [1:0] always 0
- `d_rmask`  in  4  load byte mask; nonzero = load request
- `d_wmask`  in  4  store byte mask; nonzero = store request
- `d_wdata`  in  32  store data, already byte-lane aligned
- `data_in`  out  32  word at `d_addr` (pre-store value for stores); valid only with `data_valid`
- `data_valid`  out  1  one-cycle completion pulse
- `dfp_addr`  out  32  line address, bits [4:0] = 0
- `dfp_read`  out  1  line fill request, held until `dfp_resp`
- `dfp_write`  out  1  line writeback request, held until `dfp_resp`
- `dfp_wdata`  out  256  evicted line
- `dfp_rdata`  in  256  fill data, valid with `dfp_resp`
- `dfp_resp`  in  1  one-cycle completion pulse from lower memory

## Operation
- Address split: word = `addr[4:2]`, index = `addr[5 +: log2(NUM_SETS)]`, tag = remaining upper bits.
- Per line: valid, dirty, tag, 256-bit data. Reset clears all valid/dirty; data/tag don't-care.
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE: if `d_rmask|d_wmask` nonzero, latch addr/masks/wdata -> COMPARE. Otherwise stay.
- Both masks nonzero: treated as store (wmask wins, rmask ignored).
- COMPARE, hit (valid && tag match): `data_valid`=1, `data_in`=selected word; for stores merge bytes of latched `d_wdata` where wmask set, set dirty -> IDLE.
- COMPARE, miss, line invalid or clean -> FILL; miss, valid && dirty -> WRITEBACK.
- WRITEBACK: `dfp_write`=1, `dfp_addr`={old tag, index, 5'b0}, `dfp_wdata`=line; on `dfp_resp` clear dirty -> FILL.
- FILL: `dfp_read`=1, `dfp_addr`={req tag, index, 5'b0}; on `dfp_resp` write `dfp_rdata`, valid=1, dirty=0, new tag -> COMPARE (now hits).
- `dfp_read` and `dfp_write` never both high. `dfp_resp` outside WRITEBACK/FILL is ignored.
- Request inputs are sampled only in IDLE; changes during COMPARE/WRITEBACK/FILL are ignored.

## Timing
- Reset values: `data_valid`=0, `data_in`=0, `dfp_read`=0, `dfp_write`=0, `dfp_addr`=0, `dfp_wdata`=0, state IDLE.
- Hit: request presented cycle N -> `data_valid` cycle N+1. Store write and dirty update take effect at end of N+1.
- Clean miss: `dfp_read` rises N+1; `dfp_resp` at cycle M -> `data_valid` at M+1.
- Dirty miss: `dfp_write` from N+1 to resp cycle W; `dfp_read` from W+1 to resp cycle M; `data_valid` M+1.
- Cycle after `data_valid` is IDLE. Back-to-back hits give one response every 2 cycles. The memory queue drops its request in the `data_valid` cycle, so no double-service.
- Reset mid-WRITEBACK/FILL: abandon; requests deassert next cycle; no line state updated; late `dfp_resp` ignored.
- `data_in`/`data_valid` and `dfp_*` outputs are driven combinationally from registered state only; no input-to-output combinational path.

## Structure
- Add to `rv32i_types`: `dcache_state_t` enum (IDLE, COMPARE, WRITEBACK, FILL) and `dcache_line_t` struct {valid, dirty, tag, data[255:0]}.
- Sub-module `dcache_line_array`: NUM_SETS flop array, one read port, one write port with 32-byte write-enable mask, synchronous reset of valid/dirty.
- FSM, request latch, and byte-merge logic stay in `dcache_responder`.

## Test plan
- Cold load: `d_addr`=0x1000_0004, rmask=4'hF; fill returns word1=0xDEADBEEF -> one `dfp_read` at 0x1000_0000, `data_valid` with `data_in`=0xDEADBEEF one cycle after `dfp_resp`.
- Store hit then load: sb wmask=4'b0100, `d_wdata`=0x00AB_0000 to 0x1000_0004 -> next load returns 0xDEABBEEF, no dfp traffic, each response 1 cycle after request.
- Dirty eviction: load 0x1000_0000 + store, then load 0x2000_0000 (same index, NUM_SETS=4) -> `dfp_write` at 0x1000_0000 with modified line, then `dfp_read` at 0x2000_0000, never both high.
- Back-to-back hits: requests held continuously -> `data_valid` every other cycle, none lost or duplicated.
- Reset during FILL: assert `rst` with `dfp_read` high, then `dfp_resp` pulse -> `dfp_read` low next cycle, no `data_valid`, line stays invalid (reload misses).
- Mask conflict: rmask=4'hF, wmask=4'h1 -> handled as byte store, line marked dirty.
